if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch front end: generates the PC, fetches 32-bit words from instruction memory over a
//  req/ack handshake, buffers them and presents {pc, inst, valid} to the IF/ID register feeding id.
//  Producer side of the decoder's pc_i/inst_i interface; absorbs memory latency and downstream stalls.
// PARAMETERS
//  RESET_PC    32'h0000_0000  first fetch address after reset
//  FIFO_DEPTH  2              buffered instructions (power of 2, >=2)
// PORTS
//  clk           in   1   clock, all state on rising edge
//  rst           in   1   reset, synchronous, active-high
//  imem_req_o    out  1   fetch request, held until acked
//  imem_addr_o   out  32  word address of request, stable while req high
//  imem_ack_i    in   1   memory accepts request and returns data this cycle
//  imem_rdata_i  in   32  instruction word, valid when imem_ack_i=1
//  stall_i       in   1   downstream not accepting this cycle
//  redirect_i    in   1   discard buffered/in-flight fetches, restart at redirect_pc_i
//  redirect_pc_i in   32  new fetch address; bits[1:0] forced to 2'b00
//  pc_o          out  32  address of presented instruction
//  inst_o        out  32  presented instruction; 32'h0 (sll $0 = nop) when valid_o=0
//  valid_o       out  1   pc_o/inst_o hold a real instruction
// BEHAVIOUR
//  - Reset: imem_req_o=0, imem_addr_o=RESET_PC, fetch_pc=RESET_PC, FIFO empty, valid_o=0, pc_o=0,
//    inst_o=0, state=IDLE. Reset mid-request abandons it; an ack seen in IDLE is ignored.
//  - States: IDLE (no request), REQ (req high, waiting ack), DISCARD (req high, response to be dropped).
//  - IDLE: if (count + 0) < FIFO_DEPTH -> REQ next cycle with imem_addr_o=fetch_pc. First request
//    asserted in the 1st cycle after rst deasserts.
//  - REQ, ack: push {imem_addr_o, imem_rdata_i}; fetch_pc+=4 (wraps FFFF_FFFC->0000_0000). If FIFO still
//    has a free slot after this cycle's push/pop -> stay REQ with next address (back-to-back, 1 fetch/cycle
//    at zero wait), else -> IDLE. REQ, no ack: hold req and address unchanged.
//  - Redirect: FIFO flushed same edge; fetch_pc=redirect_pc_i&~3. In REQ without ack -> DISCARD (keep
//    old address, req high). In REQ with ack -> drop that word, -> REQ on new address. In IDLE/DISCARD ->
//    fetch_pc updated; DISCARD stays until ack. DISCARD, ack -> drop word, -> IDLE. Redirect has priority
//    over push and pop. Second redirect while in DISCARD overwrites fetch_pc (last wins).
//  - Output: valid_o = FIFO non-empty; pc_o/inst_o = FIFO head (combinational from storage). Pop when
//    valid_o && !stall_i. Push and pop in same cycle allowed, including when full.
//  - Latency: zero-wait memory, empty FIFO -> instruction on valid_o the cycle after ack.
//  - stall_i never affects request issue except via FIFO occupancy; no instruction dropped or duplicated.
//  - No memory error signalling; misaligned addresses impossible by construction.
// STRUCTURE
//  - Shared defines file: InstAddrBus, InstBus, ZeroWord, RstEnable, plus new FETCH_IDLE/REQ/DISCARD
//    state encodings (2 bits) and RESET_PC default.
//  - Sub-module if_fifo: DEPTH-entry 64-bit ({pc,inst}) synchronous FIFO, push/pop/flush, count, full,
//    empty, head data; fetch FSM and PC register remain in if_fetch_unit.
// TESTING
//  - Zero-wait ack, stall_i=0: pc_o 0,4,8,C on consecutive cycles, valid_o held 1, inst_o matches ROM.
//  - Ack delayed 3 cycles per request: req/addr stable during wait; valid_o 1 cycle in 4, no gaps in pc.
//  - stall_i=1 for 5 cycles from pc=8: FIFO fills (2), req drops, pc_o stays 8; release -> 8,C,10 in order.
//  - redirect_i to 0x0000_0103 while request to 0x10 outstanding: 0x10 data dropped, next valid pc_o=0x100.
//  - Redirect with ack same cycle, and redirect_pc=FFFF_FFFC: fetches FFFF_FFFC then 0000_0000.
//  - rst asserted mid-request with ack next cycle: req_o=0 after edge, ack ignored, restart at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage definitions: bus widths, reset level, fetch FSM encodings and FIFO entry layout.
package if_fetch_unit_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstBus-1:0]     ZeroWord         = 32'h0000_0000;
  localparam logic                   RstEnable        = 1'b1;
  localparam logic [InstAddrBus-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [1:0] FETCH_IDLE    = 2'b00;
  localparam logic [1:0] FETCH_REQ     = 2'b01;
  localparam logic [1:0] FETCH_DISCARD = 2'b10;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } fetch_entry_t;

  function automatic logic [InstAddrBus-1:0] align_word(input logic [InstAddrBus-1:0] addr);
    return {addr[InstAddrBus-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_fifo.sv
// Small synchronous FIFO of {pc, inst} pairs between instruction memory and the IF/ID register.
module if_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    CNT_ONE  = 1;
  localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE  = 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst == RstEnable || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC generation, req/ack fetch FSM with redirect discard, and output FIFO.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int                     FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req_o,
  output logic [InstAddrBus-1:0] imem_addr_o,
  input  logic                   imem_ack_i,
  input  logic [InstBus-1:0]     imem_rdata_i,
  input  logic                   stall_i,
  input  logic                   redirect_i,
  input  logic [InstAddrBus-1:0] redirect_pc_i,
  output logic [InstAddrBus-1:0] pc_o,
  output logic [InstBus-1:0]     inst_o,
  output logic                   valid_o
);

  localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE   = 1;
  localparam logic [CW-1:0] CNT_DEPTH = CW'(FIFO_DEPTH);

  logic [1:0]             state;
  logic [InstAddrBus-1:0] fetch_pc;
  logic [InstAddrBus-1:0] addr_q;
  logic [InstAddrBus-1:0] next_pc;
  logic [InstAddrBus-1:0] redirect_pc;

  logic                   push;
  logic                   pop;
  logic [CW-1:0]          count;
  logic [CW-1:0]          count_after;
  logic                   full;
  logic                   empty;
  fetch_entry_t           wdata;
  fetch_entry_t           head;

  assign next_pc     = fetch_pc + 32'd4;
  assign redirect_pc = align_word(redirect_pc_i);

  // Redirect wins over both push and pop: the word returned on a redirect cycle is stale.
  assign push  = (state == FETCH_REQ) && imem_ack_i && !redirect_i;
  assign pop   = !empty && !stall_i && !redirect_i;
  assign wdata = '{pc: addr_q, inst: imem_rdata_i};

  always_comb begin
    count_after = count;
    if (push && !pop)      count_after = count + CNT_ONE;
    else if (!push && pop) count_after = count - CNT_ONE;
  end

  if_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_i),
    .wdata (wdata),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state    <= FETCH_IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
    end else begin
      case (state)
        FETCH_IDLE: begin
          if (redirect_i) begin
            fetch_pc <= redirect_pc;
          end else if (!full) begin
            state  <= FETCH_REQ;
            addr_q <= fetch_pc;
          end
        end
        FETCH_REQ: begin
          if (redirect_i) begin
            fetch_pc <= redirect_pc;
            // An unacked request cannot be withdrawn, so its response must be swallowed later.
            if (imem_ack_i) addr_q <= redirect_pc;
            else            state  <= FETCH_DISCARD;
          end else if (imem_ack_i) begin
            fetch_pc <= next_pc;
            if (count_after < CNT_DEPTH) addr_q <= next_pc;
            else                         state  <= FETCH_IDLE;
          end
        end
        FETCH_DISCARD: begin
          if (redirect_i) fetch_pc <= redirect_pc;
          if (imem_ack_i) state    <= FETCH_IDLE;
        end
        default: state <= FETCH_IDLE;
      endcase
    end
  end

  assign imem_req_o  = (state != FETCH_IDLE);
  assign imem_addr_o = addr_q;
  assign valid_o     = !empty;
  assign pc_o        = valid_o ? head.pc   : ZeroWord;
  assign inst_o      = valid_o ? head.inst : ZeroWord;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: zero-wait and slow memory, stalls, redirects and mid-request reset.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        valid;

  int tests = 0;
  int fails = 0;

  int   mem_delay = 0;
  logic force_ack = 1'b0;
  int   wcnt = 0;

  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata),
    .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .pc_o(pc), .inst_o(inst), .valid_o(valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Memory model: acks once the request has waited mem_delay cycles.
  always_comb imem_ack = force_ack || (imem_req && (wcnt >= mem_delay));
  assign imem_rdata = rom(imem_addr);

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) wcnt <= 0;
    else                              wcnt <= wcnt + 1;
  end

  // Record every instruction the downstream stage consumes.
  always @(posedge clk) begin
    if (!rst && valid && !stall && !redirect) begin
      got_pc.push_back(pc);
      got_inst.push_back(inst);
    end
  end

  task automatic apply_reset(input int d);
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; force_ack = 1'b0; mem_delay = d;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    got_pc.delete(); got_inst.delete();
  endtask

  task automatic wait_for(input logic [31:0] a, input bit on_req, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (on_req ? (imem_req && imem_addr == a) : (valid && pc == a)) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; force_ack = 1'b0; mem_delay = 0;
    repeat (2) @(negedge clk);
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", valid); end
    tests++; if (pc !== 32'h0 || inst !== 32'h0) begin fails++; $display("FAIL reset_out got=%h/%h exp=0/0", pc, inst); end
    rst = 1'b0;
    got_pc.delete(); got_inst.delete();
    @(negedge clk);
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL first_req got=%b/%h exp=1/0", imem_req, imem_addr); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL first_req_valid got=%b exp=0", valid); end
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (valid !== 1'b1 || pc !== 32'(4*i) || inst !== rom(32'(4*i))) begin
        fails++; $display("FAIL zero_wait[%0d] got=%b/%h/%h exp=1/%h/%h", i, valid, pc, inst, 32'(4*i), rom(32'(4*i)));
      end
    end
  endtask

  task automatic test_delayed_ack();
    logic        prev_req = 1'b0, prev_ack = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    int viol = 0, gap_viol = 0, nvalid = 0, last = -1, bad = 0;
    apply_reset(3);
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (prev_req && !prev_ack && (imem_req !== 1'b1 || imem_addr !== prev_addr)) viol++;
      if (valid) begin
        if (last >= 0 && i - last != 4) gap_viol++;
        last = i; nvalid++;
      end
      prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
    end
    tests++; if (viol != 0) begin fails++; $display("FAIL delayed_req_stable got=%0d exp=0", viol); end
    tests++; if (gap_viol != 0) begin fails++; $display("FAIL delayed_valid_gap got=%0d exp=0", gap_viol); end
    tests++; if (nvalid < 10 || got_pc.size() != nvalid) begin fails++; $display("FAIL delayed_count got=%0d/%0d exp>=10", nvalid, got_pc.size()); end
    foreach (got_pc[k]) if (got_pc[k] !== 32'(4*k) || got_inst[k] !== rom(32'(4*k))) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL delayed_sequence got=%0d bad exp=0", bad); end
  endtask

  task automatic test_stall();
    bit ok;
    apply_reset(0);
    wait_for(32'h8, 1'b0, ok);
    tests++; if (!ok) begin fails++; $display("FAIL stall_reach_pc8 got=timeout exp=pc 8"); end
    stall = 1'b1;
    got_pc.delete(); got_inst.delete();
    repeat (5) begin
      @(negedge clk);
      tests++; if (valid !== 1'b1 || pc !== 32'h8) begin fails++; $display("FAIL stall_hold got=%b/%h exp=1/8", valid, pc); end
    end
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL stall_req_drop got=%b exp=0", imem_req); end
    stall = 1'b0;
    repeat (12) @(negedge clk);
    tests++;
    if (got_pc.size() < 3) begin fails++; $display("FAIL stall_release got=%0d entries exp>=3", got_pc.size()); end
    else if (got_pc[0] !== 32'h8 || got_pc[1] !== 32'hC || got_pc[2] !== 32'h10 || got_inst[2] !== rom(32'h10)) begin
      fails++; $display("FAIL stall_release got=%h,%h,%h exp=8,c,10", got_pc[0], got_pc[1], got_pc[2]);
    end
  endtask

  task automatic test_redirect_outstanding(input bit twice);
    bit ok;
    logic [31:0] exp_pc;
    apply_reset(3);
    wait_for(32'h10, 1'b1, ok);
    tests++; if (!ok) begin fails++; $display("FAIL redir_reach_10 got=timeout exp=req 10"); end
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clk);
    got_pc.delete(); got_inst.delete();
    exp_pc = 32'h100;
    if (twice) begin
      redirect_pc = 32'h0000_0200; exp_pc = 32'h200;
    end else begin
      redirect = 1'b0;
    end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || valid !== 1'b0) begin
      fails++; $display("FAIL redir_discard got=%b/%h/%b exp=1/10/0", imem_req, imem_addr, valid);
    end
    @(negedge clk);
    redirect = 1'b0;
    for (int i = 0; i < 40 && got_pc.size() == 0; i++) @(negedge clk);
    tests++;
    if (got_pc.size() == 0) begin fails++; $display("FAIL redir_first got=none exp=%h", exp_pc); end
    else if (got_pc[0] !== exp_pc || got_inst[0] !== rom(exp_pc)) begin
      fails++; $display("FAIL redir_first got=%h/%h exp=%h/%h", got_pc[0], got_inst[0], exp_pc, rom(exp_pc));
    end
  endtask

  task automatic test_redirect_with_ack();
    bit ok;
    apply_reset(0);
    wait_for(32'h8, 1'b0, ok);
    tests++; if (!ok || imem_ack !== 1'b1) begin fails++; $display("FAIL redir_ack_setup got=%b/%b exp=1/1", ok, imem_ack); end
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    got_pc.delete(); got_inst.delete();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC || valid !== 1'b0) begin
      fails++; $display("FAIL redir_ack_req got=%b/%h/%b exp=1/fffffffc/0", imem_req, imem_addr, valid);
    end
    repeat (6) @(negedge clk);
    tests++;
    if (got_pc.size() < 3) begin fails++; $display("FAIL redir_wrap got=%0d entries exp>=3", got_pc.size()); end
    else if (got_pc[0] !== 32'hFFFF_FFFC || got_pc[1] !== 32'h0 || got_pc[2] !== 32'h4 || got_inst[1] !== rom(32'h0)) begin
      fails++; $display("FAIL redir_wrap got=%h,%h,%h exp=fffffffc,0,4", got_pc[0], got_pc[1], got_pc[2]);
    end
  endtask

  task automatic test_reset_mid_request();
    bit ok;
    apply_reset(3);
    wait_for(32'h8, 1'b1, ok);
    tests++; if (!ok) begin fails++; $display("FAIL rstmid_reach_8 got=timeout exp=req 8"); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; force_ack = 1'b1;
    tests++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || valid !== 1'b0) begin
      fails++; $display("FAIL rstmid_idle got=%b/%h/%b exp=0/0/0", imem_req, imem_addr, valid);
    end
    @(negedge clk);
    force_ack = 1'b0; mem_delay = 0;
    got_pc.delete(); got_inst.delete();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid !== 1'b0) begin
      fails++; $display("FAIL rstmid_restart got=%b/%h/%b exp=1/0/0", imem_req, imem_addr, valid);
    end
    repeat (5) @(negedge clk);
    tests++;
    if (got_pc.size() < 3) begin fails++; $display("FAIL rstmid_seq got=%0d entries exp>=3", got_pc.size()); end
    else if (got_pc[0] !== 32'h0 || got_pc[1] !== 32'h4 || got_pc[2] !== 32'h8 || got_inst[0] !== rom(32'h0)) begin
      fails++; $display("FAIL rstmid_seq got=%h,%h,%h exp=0,4,8", got_pc[0], got_pc[1], got_pc[2]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=hung exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    test_reset();
    test_zero_wait();
    test_delayed_ack();
    test_stall();
    test_redirect_outstanding(1'b0);
    test_redirect_outstanding(1'b1);
    test_redirect_with_ack();
    test_reset_mid_request();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
